phy_tx_lane_scheduler: RTL and testbench

//  Shares the single PHY TX serializer among four 8-bit byte lanes (In0..In3 sources).

---
 rtl/phy_tx_lane_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_phy_tx_lane_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_lane_scheduler.sv
// phy_tx_lane_scheduler
// Shares one PHY TX serializer between four byte lanes. After link enable it
// sends a COM training burst, then grants lanes round-robin one byte per slot,
// fills empty slots with IDLE and periodically inserts a COM+SKP ordered set.
module phy_tx_lane_scheduler #(
    parameter int         TRAIN_LEN    = 4,
    parameter int         SKP_INTERVAL = 16,
    parameter int         SKP_LEN      = 2,
    parameter logic [7:0] COM_SYM      = 8'hBC,
    parameter logic [7:0] SKP_SYM      = 8'h1C,
    parameter logic [7:0] IDLE_SYM     = 8'h7C
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       link_en,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic       valid0,
    input  logic       valid1,
    input  logic       valid2,
    input  logic       valid3,
    output logic       ready0,
    output logic       ready1,
    output logic       ready2,
    output logic       ready3,
    input  logic       ser_ready,
    output logic [7:0] tx_data,
    output logic       tx_k,
    output logic       tx_valid,
    output logic       link_up,
    output logic [1:0] cur_lane
);

    localparam logic [1:0] ST_OFF    = 2'd0;
    localparam logic [1:0] ST_TRAIN  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_SKP    = 2'd3;

    // Counter widths sized so the terminal value always fits; no counter ever
    // counts past its terminal value, so nothing can overflow.
    localparam int TW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
    localparam int SW = $clog2(SKP_INTERVAL);
    localparam int KW = (SKP_LEN > 1) ? $clog2(SKP_LEN) : 1;

    localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_LEN - 1);
    localparam logic [SW-1:0] SYM_LAST   = SW'(SKP_INTERVAL - 1);
    localparam logic [KW-1:0] SKP_LAST   = KW'(SKP_LEN - 1);

    logic [1:0]    state_reg;
    logic [TW-1:0] train_cnt_reg;
    logic [SW-1:0] sym_cnt_reg;
    logic [KW-1:0] skp_cnt_reg;
    logic [1:0]    cur_lane_reg;
    logic [7:0]    tx_data_reg;
    logic          tx_k_reg;
    logic          tx_valid_reg;

    logic [7:0] lane_data [4];
    logic [3:0] lane_valid;
    logic [1:0] cand [4];
    logic [3:0] cand_valid;
    logic       found_next;
    logic [1:0] sel_next;
    logic       grant_en;
    logic [3:0] ready_vec;

    assign lane_data[0] = in0;
    assign lane_data[1] = in1;
    assign lane_data[2] = in2;
    assign lane_data[3] = in3;
    assign lane_valid   = {valid3, valid2, valid1, valid0};

    // Candidate gi is the lane gi+1 places after the last grant (wraps 3->0).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cand
            assign cand[gi]       = cur_lane_reg + 2'(gi + 1);
            assign cand_valid[gi] = lane_valid[cand[gi]];
        end
    endgenerate

    // Round-robin search: the nearest valid candidate after cur_lane wins.
    always_comb begin
        found_next = 1'b0;
        sel_next   = cur_lane_reg;
        for (int k = 3; k >= 0; k--) begin
            if (cand_valid[k]) begin
                found_next = 1'b1;
                sel_next   = cand[k];
            end
        end
    end

    // A data slot exists only in ACTIVE when the serializer takes a symbol and
    // the slot is not reserved for the COM of a SKP ordered set.
    assign grant_en = (state_reg == ST_ACTIVE) && ser_ready && (sym_cnt_reg != SYM_LAST);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ready
            assign ready_vec[gi] = grant_en && found_next && (sel_next == 2'(gi));
        end
    endgenerate

    assign ready0   = ready_vec[0];
    assign ready1   = ready_vec[1];
    assign ready2   = ready_vec[2];
    assign ready3   = ready_vec[3];
    assign tx_data  = tx_data_reg;
    assign tx_k     = tx_k_reg;
    assign tx_valid = tx_valid_reg;
    assign link_up  = (state_reg == ST_ACTIVE);
    assign cur_lane = cur_lane_reg;

    // Link state machine, symbol selection and registered serializer outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_OFF;
            train_cnt_reg <= '0;
            sym_cnt_reg   <= '0;
            skp_cnt_reg   <= '0;
            cur_lane_reg  <= 2'd3;
            tx_data_reg   <= 8'h00;
            tx_k_reg      <= 1'b0;
            tx_valid_reg  <= 1'b0;
        end else if ((state_reg != ST_OFF) && !link_en) begin
            // Link shutdown: a lane that saw ready at this edge counts as sent.
            state_reg    <= ST_OFF;
            tx_valid_reg <= 1'b0;
            if (|ready_vec) begin
                cur_lane_reg <= sel_next;
            end
        end else begin
            case (state_reg)
                ST_OFF: begin
                    tx_valid_reg <= 1'b0;
                    if (link_en) begin
                        state_reg     <= ST_TRAIN;
                        train_cnt_reg <= '0;
                    end
                end
                ST_TRAIN: begin
                    if (ser_ready) begin
                        tx_data_reg  <= COM_SYM;
                        tx_k_reg     <= 1'b1;
                        tx_valid_reg <= 1'b1;
                        if (train_cnt_reg == TRAIN_LAST) begin
                            state_reg   <= ST_ACTIVE;
                            sym_cnt_reg <= '0;
                        end else begin
                            train_cnt_reg <= train_cnt_reg + TW'(1);
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (ser_ready) begin
                        tx_valid_reg <= 1'b1;
                        if (sym_cnt_reg == SYM_LAST) begin
                            tx_data_reg <= COM_SYM;
                            tx_k_reg    <= 1'b1;
                            state_reg   <= ST_SKP;
                            skp_cnt_reg <= '0;
                            sym_cnt_reg <= '0;
                        end else begin
                            if (found_next) begin
                                tx_data_reg  <= lane_data[sel_next];
                                tx_k_reg     <= 1'b0;
                                cur_lane_reg <= sel_next;
                            end else begin
                                tx_data_reg <= IDLE_SYM;
                                tx_k_reg    <= 1'b1;
                            end
                            sym_cnt_reg <= sym_cnt_reg + SW'(1);
                        end
                    end
                end
                default: begin
                    if (ser_ready) begin
                        tx_data_reg  <= SKP_SYM;
                        tx_k_reg     <= 1'b1;
                        tx_valid_reg <= 1'b1;
                        if (skp_cnt_reg == SKP_LAST) begin
                            state_reg <= ST_ACTIVE;
                        end else begin
                            skp_cnt_reg <= skp_cnt_reg + KW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phy_tx_lane_scheduler.sv
// Testbench for phy_tx_lane_scheduler: randomized lane traffic compared against
// a stream-position model of the link (training burst, then a repeating frame
// of data/idle slots followed by a COM+SKP ordered set).
module tb_phy_tx_lane_scheduler;

    localparam int TL = 4;
    localparam int SI = 16;
    localparam int SL = 2;
    localparam int P  = SI + SL;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       link_en = 1'b0;
    logic       ser_ready = 1'b0;
    logic [7:0] in_d [4];
    logic [3:0] valid_d = 4'h0;
    logic       r0, r1, r2, r3;
    logic [7:0] tx_data;
    logic       tx_k, tx_valid, link_up;
    logic [1:0] cur_lane;
    logic [3:0] ready_vec;

    int total = 0;
    int passed = 0;

    // model state
    int         m_run = 0;
    int         m_n = 0;
    int         m_last = 3;
    logic [7:0] m_data = 8'h00;
    logic       m_k = 1'b0;
    logic       m_valid = 1'b0;

    always #5 clk = ~clk;

    assign ready_vec = {r3, r2, r1, r0};

    phy_tx_lane_scheduler dut (
        .clk(clk), .reset(reset), .link_en(link_en),
        .in0(in_d[0]), .in1(in_d[1]), .in2(in_d[2]), .in3(in_d[3]),
        .valid0(valid_d[0]), .valid1(valid_d[1]), .valid2(valid_d[2]), .valid3(valid_d[3]),
        .ready0(r0), .ready1(r1), .ready2(r2), .ready3(r3),
        .ser_ready(ser_ready), .tx_data(tx_data), .tx_k(tx_k), .tx_valid(tx_valid),
        .link_up(link_up), .cur_lane(cur_lane)
    );

    // Position inside the post-training frame of the next symbol to be sent.
    function automatic int m_pos();
        return (m_n - TL) % P;
    endfunction

    function automatic logic m_active();
        return (m_run != 0) && (m_n >= TL) && (m_pos() < SI);
    endfunction

    // Lane that the link takes this cycle, or -1.
    function automatic int m_grant();
        if (m_run == 0 || !ser_ready || m_n < TL || m_pos() >= SI - 1) return -1;
        for (int k = 1; k <= 4; k++) begin
            if (valid_d[(m_last + k) % 4]) return (m_last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_ready();
        int g;
        g = m_grant();
        return (g >= 0) ? 4'(1 << g) : 4'h0;
    endfunction

    function automatic logic [12:0] m_out();
        return {m_valid, m_k, m_data, m_active(), 2'(m_last)};
    endfunction

    // One clock: advance the model with the inputs seen at the edge.
    task automatic tick(output int g);
        int pos;
        g = m_grant();
        @(posedge clk);
        if (reset) begin
            m_run = 0; m_n = 0; m_last = 3; m_data = 8'h00; m_k = 1'b0; m_valid = 1'b0;
        end else if (m_run == 0) begin
            m_valid = 1'b0;
            if (link_en) begin
                m_run = 1;
                m_n = 0;
            end
        end else if (!link_en) begin
            if (g >= 0) m_last = g;
            m_run = 0;
            m_valid = 1'b0;
        end else if (ser_ready) begin
            m_valid = 1'b1;
            if (m_n < TL) begin
                m_data = 8'hBC; m_k = 1'b1;
            end else begin
                pos = m_pos();
                if (pos < SI - 1) begin
                    if (g >= 0) begin
                        m_data = in_d[g]; m_k = 1'b0; m_last = g;
                    end else begin
                        m_data = 8'h7C; m_k = 1'b1;
                    end
                end else if (pos == SI - 1) begin
                    m_data = 8'hBC; m_k = 1'b1;
                end else begin
                    m_data = 8'h1C; m_k = 1'b1;
                end
            end
            m_n++;
        end
        @(negedge clk);
    endtask

    // Lane sources: refill a granted lane, occasionally raise or drop others.
    task automatic src_random(input int g);
        for (int i = 0; i < 4; i++) begin
            if (i == g) begin
                in_d[i] = 8'($urandom);
                valid_d[i] = 1'($urandom_range(0, 1));
            end else if (!valid_d[i] && $urandom_range(0, 2) == 0) begin
                in_d[i] = 8'($urandom);
                valid_d[i] = 1'b1;
            end else if (valid_d[i] && $urandom_range(0, 15) == 0) begin
                valid_d[i] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        int g;
        reset = 1'b1; link_en = 1'b0; ser_ready = 1'b0; valid_d = 4'h0;
        for (int i = 0; i < 4; i++) in_d[i] = 8'h00;
        tick(g);
        tick(g);
        total++;
        if ({tx_valid, tx_k, tx_data, link_up, cur_lane} !== 13'b0_0_00000000_0_11) begin
            $display("FAIL reset_outputs got=%h want=%h", {tx_valid, tx_k, tx_data, link_up, cur_lane}, 13'b0_0_00000000_0_11);
        end else passed++;
        total++;
        if (ready_vec !== 4'h0) $display("FAIL reset_ready got=%b want=0000", ready_vec);
        else passed++;
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_train_idle();
        int g, coms;
        logic [3:0] er;
        coms = 0;
        link_en = 1'b1; ser_ready = 1'b1; valid_d = 4'h0;
        for (int c = 0; c < 40; c++) begin
            #1;
            er = m_ready();
            total++;
            if (ready_vec !== er) $display("FAIL train_ready cyc=%0d got=%b want=%b", c, ready_vec, er);
            else passed++;
            tick(g);
            total++;
            if ({tx_valid, tx_k, tx_data, link_up, cur_lane} !== m_out())
                $display("FAIL train_out cyc=%0d got=%h want=%h", c, {tx_valid, tx_k, tx_data, link_up, cur_lane}, m_out());
            else passed++;
            if (c < 6 && tx_valid && tx_k && tx_data == 8'hBC) coms++;
            $display("train cyc=%0d tx=%h k=%b v=%b up=%b", c, tx_data, tx_k, tx_valid, link_up);
        end
        total++;
        if (coms !== TL) $display("FAIL train_com_count got=%0d want=%0d", coms, TL);
        else passed++;
    endtask

    task automatic test_all_valid();
        int g;
        logic [3:0] er;
        in_d[0] = 8'hFF; in_d[1] = 8'hEE; in_d[2] = 8'hDD; in_d[3] = 8'hCC;
        valid_d = 4'hF;
        for (int c = 0; c < 24; c++) begin
            #1;
            er = m_ready();
            total++;
            if (ready_vec !== er) $display("FAIL allv_ready cyc=%0d got=%b want=%b", c, ready_vec, er);
            else passed++;
            tick(g);
            total++;
            if ({tx_valid, tx_k, tx_data, link_up, cur_lane} !== m_out())
                $display("FAIL allv_out cyc=%0d got=%h want=%h", c, {tx_valid, tx_k, tx_data, link_up, cur_lane}, m_out());
            else passed++;
            $display("allv cyc=%0d grant=%0d tx=%h k=%b", c, g, tx_data, tx_k);
        end
    endtask

    task automatic test_single_lane();
        int g;
        logic [3:0] er;
        valid_d = 4'b0100; in_d[2] = 8'h99;
        for (int c = 0; c < 24; c++) begin
            #1;
            er = m_ready();
            total++;
            if (ready_vec !== er) $display("FAIL single_ready cyc=%0d got=%b want=%b", c, ready_vec, er);
            else passed++;
            tick(g);
            total++;
            if ({tx_valid, tx_k, tx_data, link_up, cur_lane} !== m_out())
                $display("FAIL single_out cyc=%0d got=%h want=%h", c, {tx_valid, tx_k, tx_data, link_up, cur_lane}, m_out());
            else passed++;
            $display("single cyc=%0d grant=%0d tx=%h k=%b", c, g, tx_data, tx_k);
        end
    endtask

    task automatic test_ser_ready_toggle();
        int g;
        logic [3:0] er;
        for (int i = 0; i < 4; i++) in_d[i] = 8'($urandom);
        valid_d = 4'hF;
        for (int c = 0; c < 40; c++) begin
            ser_ready = (c % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            er = m_ready();
            total++;
            if (ready_vec !== er) $display("FAIL serrdy_ready cyc=%0d got=%b want=%b", c, ready_vec, er);
            else passed++;
            tick(g);
            total++;
            if ({tx_valid, tx_k, tx_data, link_up, cur_lane} !== m_out())
                $display("FAIL serrdy_out cyc=%0d got=%h want=%h", c, {tx_valid, tx_k, tx_data, link_up, cur_lane}, m_out());
            else passed++;
            if (g >= 0) in_d[g] = 8'($urandom);
            $display("serrdy cyc=%0d sr=%b grant=%0d tx=%h", c, ser_ready, g, tx_data);
        end
        ser_ready = 1'b1;
    endtask

    task automatic test_link_drop();
        int g, n;
        logic [3:0] er;
        n = 0;
        while (!(m_run != 0 && m_n >= TL && !m_active()) && n < 100) begin
            src_random(-1);
            tick(g);
            if (g >= 0) src_random(g);
            n++;
        end
        total++;
        if (n >= 100) $display("FAIL drop_reach_skp got=timeout want=skp");
        else passed++;
        link_en = 1'b0;
        tick(g);
        total++;
        if ({tx_valid, link_up} !== 2'b00 || {tx_valid, tx_k, tx_data, link_up, cur_lane} !== m_out())
            $display("FAIL drop_off got=%h want=%h", {tx_valid, tx_k, tx_data, link_up, cur_lane}, m_out());
        else passed++;
        $display("drop tx_valid=%b link_up=%b", tx_valid, link_up);
        tick(g);
        link_en = 1'b1;
        for (int c = 0; c < 30; c++) begin
            src_random(-1);
            #1;
            er = m_ready();
            total++;
            if (ready_vec !== er) $display("FAIL retrain_ready cyc=%0d got=%b want=%b", c, ready_vec, er);
            else passed++;
            tick(g);
            total++;
            if ({tx_valid, tx_k, tx_data, link_up, cur_lane} !== m_out())
                $display("FAIL retrain_out cyc=%0d got=%h want=%h", c, {tx_valid, tx_k, tx_data, link_up, cur_lane}, m_out());
            else passed++;
            if (g >= 0) src_random(g);
            $display("retrain cyc=%0d tx=%h k=%b up=%b", c, tx_data, tx_k, link_up);
        end
    endtask

    task automatic test_reset_mid();
        int g, n;
        logic [3:0] er;
        n = 0;
        valid_d = 4'hF;
        while (!(m_last == 1 && m_active()) && n < 100) begin
            tick(g);
            n++;
        end
        total++;
        if (n >= 100) $display("FAIL midrst_reach got=timeout want=lane1");
        else passed++;
        reset = 1'b1;
        tick(g);
        total++;
        if ({tx_valid, tx_k, tx_data, link_up, cur_lane} !== 13'b0_0_00000000_0_11)
            $display("FAIL midrst_outputs got=%h want=%h", {tx_valid, tx_k, tx_data, link_up, cur_lane}, 13'b0_0_00000000_0_11);
        else passed++;
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            er = m_ready();
            total++;
            if (ready_vec !== er) $display("FAIL midrst_ready cyc=%0d got=%b want=%b", c, ready_vec, er);
            else passed++;
            tick(g);
            total++;
            if ({tx_valid, tx_k, tx_data, link_up, cur_lane} !== m_out())
                $display("FAIL midrst_out cyc=%0d got=%h want=%h", c, {tx_valid, tx_k, tx_data, link_up, cur_lane}, m_out());
            else passed++;
            $display("midrst cyc=%0d grant=%0d lane=%0d tx=%h", c, g, cur_lane, tx_data);
        end
    endtask

    task automatic test_random();
        int g;
        logic [3:0] er;
        for (int c = 0; c < 300; c++) begin
            ser_ready = ($urandom_range(0, 3) != 0);
            link_en = ($urandom_range(0, 60) != 0);
            #1;
            er = m_ready();
            total++;
            if (ready_vec !== er) $display("FAIL random_ready cyc=%0d got=%b want=%b", c, ready_vec, er);
            else passed++;
            tick(g);
            total++;
            if ({tx_valid, tx_k, tx_data, link_up, cur_lane} !== m_out())
                $display("FAIL random_out cyc=%0d got=%h want=%h", c, {tx_valid, tx_k, tx_data, link_up, cur_lane}, m_out());
            else passed++;
            src_random(g);
            $display("random cyc=%0d sr=%b en=%b grant=%0d tx=%h k=%b v=%b", c, ser_ready, link_en, g, tx_data, tx_k, tx_valid);
        end
    endtask

    initial begin
        test_reset();
        test_train_idle();
        test_all_valid();
        test_single_lane();
        test_ser_ready_toggle();
        test_link_drop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
